// File: rtl/demux_router.sv
// demux_router: routes one input word stream to N_OUT channels, each with a
// one-entry holding register and a valid/ready handshake. Supports unicast and
// broadcast writes, drops writes to out-of-range selects, and counts the drops.
module demux_router #(
    parameter int DATA_W    = 16,
    parameter int N_OUT     = 14,
    parameter int SEL_W     = $clog2(N_OUT),
    parameter bit ZERO_IDLE = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_sel,
    output logic [CNT_W-1:0]        drop_cnt
);

    // Channel count widened by one bit so the range compare works even when
    // N_OUT is an exact power of two (then every select is in range).
    localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W + 1)'(N_OUT);

    // Saturating increment for the drop counter: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] slot_p0 [N_OUT];
    logic [N_OUT-1:0]  vld_p0;
    logic [N_OUT-1:0]  free;
    logic [N_OUT-1:0]  wr_en;
    logic              sel_ok;
    logic              sel_free;
    logic              accept;
    logic              drop;

    // Handshake decode: slot availability, in_ready, per-channel write enables.
    always_comb begin
        free     = ~vld_p0 | out_ready;
        sel_ok   = ({1'b0, in_sel} < N_OUT_EXT);
        sel_free = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) sel_free = free[k];
        end
        if (in_bcast)    in_ready = &free;
        else if (sel_ok) in_ready = sel_free;
        else             in_ready = 1'b1;
        accept = in_valid & in_ready;
        drop   = accept & ~in_bcast & ~sel_ok;
        wr_en  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            wr_en[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
        end
    end

    // Stage p0: holding registers; a write wins over a drain on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= '0;
            for (int k = 0; k < N_OUT; k++) slot_p0[k] <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_en[k]) begin
                    slot_p0[k] <= in_data;
                    vld_p0[k]  <= 1'b1;
                end else if (out_ready[k]) begin
                    vld_p0[k]  <= 1'b0;
                end
            end
        end
    end

    // Dropped-write reporting: one-cycle error pulse and saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_sel <= drop;
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Output view: idle channels read zero or keep their last word.
    always_comb begin
        out_valid = vld_p0;
        out_data  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_data[k*DATA_W +: DATA_W] = (ZERO_IDLE && !vld_p0[k]) ? '0 : slot_p0[k];
        end
    end

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: table-driven unicast/drop vectors, hand-written
// throughput, broadcast, saturation, idle-data and async-reset sequences, and
// randomized traffic checked against a behavioural channel model.
module tb_demux_router;

    localparam int DW = 16;
    localparam int N  = 14;
    localparam int SW = 4;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic            in_bcast;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic            err_sel;
    logic [CW-1:0]   drop_cnt;

    logic            h_in_ready;
    logic [N-1:0]    h_out_valid;
    logic [N*DW-1:0] h_out_data;
    logic            h_err_sel;
    logic [CW-1:0]   h_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: per-channel occupancy and last word, drop reporting.
    bit            mv [N];
    logic [DW-1:0] md [N];
    bit            merr;
    int            mcnt;

    demux_router #(.DATA_W(DW), .N_OUT(N), .ZERO_IDLE(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_sel(err_sel), .drop_cnt(drop_cnt)
    );

    demux_router #(.DATA_W(DW), .N_OUT(N), .ZERO_IDLE(1'b0), .CNT_W(CW)) u_hold (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .err_sel(h_err_sel), .drop_cnt(h_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        int            sel;
        bit            bc;
        logic [DW-1:0] d;
        logic [N-1:0]  ordy;
        bit            exp_rdy;
        logic [N-1:0]  exp_vld;
        logic [DW-1:0] exp_d3;
        bit            exp_err;
        int            exp_cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_ready(input bit bc, input int sel, input logic [N-1:0] ordy);
        bit r;
        if (bc) begin
            r = 1'b1;
            for (int k = 0; k < N; k++) if (mv[k] && !ordy[k]) r = 1'b0;
        end else if (sel < N) begin
            r = !mv[sel] || ordy[sel];
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] model_data(input bit zero_idle);
        logic [N*DW-1:0] e;
        for (int k = 0; k < N; k++) e[k*DW +: DW] = (zero_idle && !mv[k]) ? '0 : md[k];
        return e;
    endfunction

    function automatic logic [N-1:0] model_valid();
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = mv[k];
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        merr = 1'b0;
        mcnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vld"},   out_valid,   model_valid());
        chk({tag, "_data"},  out_data,    model_data(1'b1));
        chk({tag, "_err"},   err_sel,     merr);
        chk({tag, "_cnt"},   drop_cnt,    mcnt);
        chk({tag, "_hvld"},  h_out_valid, model_valid());
        chk({tag, "_hdata"}, h_out_data,  model_data(1'b0));
        chk({tag, "_hcnt"},  h_drop_cnt,  mcnt);
    endtask

    // One clock cycle; called just after a falling edge, returns after the next one.
    task automatic cycle(input bit v, input int sel, input bit bc, input logic [DW-1:0] d,
                         input logic [N-1:0] ordy, output bit rdy_seen, output bit acc);
        bit r;
        in_valid  = v;
        in_sel    = SW'(sel);
        in_bcast  = bc;
        in_data   = d;
        out_ready = ordy;
        #1;
        r = model_ready(bc, sel, ordy);
        rdy_seen = in_ready;
        chk("in_ready", in_ready, r);
        chk("h_in_ready", h_in_ready, r);
        acc = v && r;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (acc && (bc || sel == k)) begin
                mv[k] = 1'b1;
                md[k] = d;
            end else if (ordy[k]) begin
                mv[k] = 1'b0;
            end
        end
        merr = acc && !bc && sel >= N;
        if (merr && mcnt < 255) mcnt++;
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    initial begin
        bit rdy, acc;
        bit pv, pbc, pacc;
        int psel;
        logic [DW-1:0] pd;

        tbl[0] = '{1'b1,  3, 1'b0, 16'hA5A5, 14'h0000, 1'b1, 14'h0008, 16'hA5A5, 1'b0, 0};
        tbl[1] = '{1'b1,  3, 1'b0, 16'h1111, 14'h0000, 1'b0, 14'h0008, 16'hA5A5, 1'b0, 0};
        tbl[2] = '{1'b1,  4, 1'b0, 16'h2222, 14'h0000, 1'b1, 14'h0018, 16'hA5A5, 1'b0, 0};
        tbl[3] = '{1'b0,  0, 1'b0, 16'h0000, 14'h0008, 1'b1, 14'h0010, 16'h0000, 1'b0, 0};
        tbl[4] = '{1'b1, 14, 1'b0, 16'hFFFF, 14'h0000, 1'b1, 14'h0010, 16'h0000, 1'b1, 1};
        tbl[5] = '{1'b1, 15, 1'b0, 16'hFFFF, 14'h0000, 1'b1, 14'h0010, 16'h0000, 1'b1, 2};
        tbl[6] = '{1'b0,  0, 1'b0, 16'h0000, 14'h0000, 1'b1, 14'h0010, 16'h0000, 1'b0, 2};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0;
        in_data = '0; out_ready = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst");
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Unicast, blocking and invalid-select vectors
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].v, tbl[i].sel, tbl[i].bc, tbl[i].d, tbl[i].ordy, rdy, acc);
            chk("tbl_rdy", rdy, tbl[i].exp_rdy);
            chk("tbl_vld", out_valid, tbl[i].exp_vld);
            chk("tbl_d3",  out_data[3*DW +: DW], tbl[i].exp_d3);
            chk("tbl_err", err_sel, tbl[i].exp_err);
            chk("tbl_cnt", drop_cnt, tbl[i].exp_cnt);
        end

        // Back-to-back throughput on ch5
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 5, 1'b0, DW'(i + 1), 14'h0020, rdy, acc);
            chk("thru_rdy", rdy, 1'b1);
            chk("thru_d5", out_data[5*DW +: DW], DW'(i + 1));
        end
        cycle(1'b0, 0, 1'b0, '0, 14'h0020, rdy, acc);
        chk("thru_drained", out_valid[5], 1'b0);

        // Broadcast blocked by a full channel, released by its consumer
        cycle(1'b0, 0, 1'b0, '0, '1, rdy, acc);
        cycle(1'b1, 7, 1'b0, 16'h7777, '0, rdy, acc);
        cycle(1'b1, 0, 1'b1, 16'h1234, '0, rdy, acc);
        chk("bc_blocked", rdy, 1'b0);
        cycle(1'b1, 0, 1'b1, 16'h1234, 14'h0080, rdy, acc);
        chk("bc_accept", rdy, 1'b1);
        chk("bc_vld", out_valid, 14'h3FFF);
        for (int k = 0; k < N; k++) chk("bc_data", out_data[k*DW +: DW], 16'h1234);
        cycle(1'b0, 0, 1'b0, '0, '1, rdy, acc);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 14 + int'($urandom_range(0, 1)), 1'b0, DW'($urandom),
                  N'($urandom), rdy, acc);
        end
        chk("sat_cnt", drop_cnt, 8'hFF);
        chk("sat_err", err_sel, 1'b1);
        cycle(1'b0, 0, 1'b0, '0, '0, rdy, acc);
        chk("sat_err_clr", err_sel, 1'b0);

        // Idle data view after drain
        cycle(1'b1, 2, 1'b0, 16'hBEEF, '0, rdy, acc);
        cycle(1'b0, 0, 1'b0, '0, 14'h0004, rdy, acc);
        chk("zi1_d2", out_data[2*DW +: DW], 16'h0000);
        chk("zi0_d2", h_out_data[2*DW +: DW], 16'hBEEF);
        chk("zi_vld2", out_valid[2], 1'b0);

        // Randomized traffic with the producer hold rule
        pv = 1'b0; pacc = 1'b0; psel = 0; pbc = 1'b0; pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(pv && !pacc)) begin
                pv   = ($urandom % 4) != 0;
                pbc  = ($urandom % 8) == 0;
                psel = int'($urandom_range(0, 15));
                pd   = DW'($urandom);
            end
            cycle(pv, psel, pbc, pd, N'($urandom), rdy, pacc);
        end

        // Asynchronous reset between clock edges
        cycle(1'b1, 0, 1'b0, 16'h0A0A, '0, rdy, acc);
        cycle(1'b1, 1, 1'b0, 16'h0B0B, '0, rdy, acc);
        cycle(1'b1, 14, 1'b0, 16'h0C0C, '0, rdy, acc);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 0, 1'b0, 16'h0C0C, '0, rdy, acc);
        chk("arst_wr_vld", out_valid, 14'h0001);
        chk("arst_wr_d0", out_data[0 +: DW], 16'h0C0C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
